md5_round_ctrl: RTL
===================

Name: md5_round_ctrl

Overview:
- Sequencing FSM for the 64-step MD5-style hash datapath.
- Drives message/state loading, the per-step random-index generator handshake (start_rnd/Done_rnd), F latching, and the A/B/C/D register update. Steps end on the datapath step counter carry (cout).
- Exposes a start/busy/done/err handshake to the host.

Parameters:
- N_STEPS, 64, steps per block; informational, termination is by cout.
- RND_TIMEOUT, 16, max cycles in WAIT_RND before error.
- TW, 5, width of timeout counter; must satisfy 2^TW > RND_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  host request; sampled only in IDLE.
- Done_rnd  in  1  index generator finished for current step.
- cout  in  1  step counter carry; high when counter value = 63.
- en_m  out  1  load msg into M0..M3.
- load  out  1  seed index generator.
- A_sel, B_sel, C_sel, D_sel  out  1 each  1 = select initial a0/b0/c0/d0.
- en_regs  out  1  A/B/C/D register enable.
- start_rnd  out  1  one-cycle index request.
- shift_en, xor_en  out  1 each  index generator run enables.
- en_F  out  1  latch F register.
- F_sel  out  1  held 0, selects round-function output.
- en_c  out  1  step counter increment.
- busy  out  1  high from LOAD through UPD.
- done  out  1  one-cycle completion pulse; digest valid from this cycle until next start.
- err  out  1  Done_rnd timeout; sticky until next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE, timeout counter=0, all outputs 0. A reset mid-block abandons the block and leaves no residual pulse.
- Moore outputs, registered state; all outputs 0 unless listed for the current state.
- IDLE: busy=0. If start=1, go to LOAD and clear err.
- LOAD (1 cycle): en_m=1, load=1, en_regs=1, A/B/C/D_sel=1, busy=1. Go to RND.
- RND (1 cycle): start_rnd=1, busy=1. Clear timeout counter. Go to WAIT_RND.
- WAIT_RND: shift_en=1, xor_en=1, busy=1.
  - Done_rnd=1: go to FSTEP.
  - Timeout counter = RND_TIMEOUT-1 and Done_rnd=0: go to ERR.
  - Otherwise increment timeout counter.
  - Done_rnd=1 takes priority over timeout in the same cycle.
- FSTEP (1 cycle): en_F=1, busy=1. Go to UPD.
- UPD (1 cycle): en_regs=1 (sels 0), en_c=1, busy=1. If cout=1, go to DONE; else go to RND.
  - cout is sampled in the same cycle the counter wraps 63→0.
- DONE (1 cycle): done=1, busy=0. Go to IDLE.
- ERR (1 cycle): err set, busy=0. Go to IDLE. err holds until the next start is accepted.
- start outside IDLE: ignored, not queued.
- Done_rnd outside WAIT_RND: ignored.
- Latency, with Done_rnd on the first WAIT_RND cycle: 4 cycles/step. done rises 1+64×4 = 257 rising edges after the edge that captured start.
- The counter value is owned by the datapath; this block only increments it. The counter reaches 0 via reset, and 64 steps return it to 0.

Test Plan:
- Reset: hold rst=0 mid-WAIT_RND → all outputs 0 immediately (async); release → IDLE, busy=0.
- Nominal: Done_rnd returned 1 cycle after start_rnd, cout modelled by a 6-bit counter.
  - start pulse → exactly 64 start_rnd, 64 en_F, 64 en_c pulses.
  - done at edge 257 after capture; busy high 256+1 cycles.
- Slow index: Done_rnd delayed 5 cycles on step 10 → that step takes 8 cycles; done at edge 261; shift_en/xor_en high only during wait.
- Timeout: never return Done_rnd on step 3 → ERR after 16 WAIT_RND cycles, err=1, busy=0, done never pulses. Next start clears err and completes normally.
- Start while busy: assert start at cycles 2 and 100 → ignored; one done only. start held high across DONE → new block begins on the IDLE cycle after done.
- Boundary: Done_rnd and timeout expiry in the same cycle → FSTEP taken, no err. cout forced high at step 0 → DONE after first UPD.

Source files
------------

// File: rtl/md5_round_ctrl.sv
// md5_round_ctrl: step sequencer for the 64-step MD5 datapath.
// Host handshake on start/busy/done/err, index-gen handshake per step.
module md5_round_ctrl #(
  parameter int N_STEPS     = 64,
  parameter int RND_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic Done_rnd,
  input  logic cout,
  output logic en_m,
  output logic load,
  output logic A_sel,
  output logic B_sel,
  output logic C_sel,
  output logic D_sel,
  output logic en_regs,
  output logic start_rnd,
  output logic shift_en,
  output logic xor_en,
  output logic en_F,
  output logic F_sel,
  output logic en_c,
  output logic busy,
  output logic done,
  output logic err
);

  if ((1 << TW) <= RND_TIMEOUT || N_STEPS < 1)
  begin : g_bad_cfg
    $error("md5_round_ctrl: bad TW/N_STEPS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RND,
    S_WAIT,
    S_FSTEP,
    S_UPD,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TW-1:0] T_LAST =
    TW'(RND_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          init_sel;
  logic          run_en;

  assign A_sel    = init_sel;
  assign B_sel    = init_sel;
  assign C_sel    = init_sel;
  assign D_sel    = init_sel;
  assign shift_en = run_en;
  assign xor_en   = run_en;
  assign F_sel    = 1'b0;

  // Sequencer: next state and the outputs of that state, registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      en_m      <= 1'b0;
      load      <= 1'b0;
      init_sel  <= 1'b0;
      en_regs   <= 1'b0;
      start_rnd <= 1'b0;
      run_en    <= 1'b0;
      en_F      <= 1'b0;
      en_c      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      en_m      <= 1'b0;
      load      <= 1'b0;
      init_sel  <= 1'b0;
      en_regs   <= 1'b0;
      start_rnd <= 1'b0;
      run_en    <= 1'b0;
      en_F      <= 1'b0;
      en_c      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            err      <= 1'b0;
            en_m     <= 1'b1;
            load     <= 1'b1;
            init_sel <= 1'b1;
            en_regs  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          state     <= S_RND;
          start_rnd <= 1'b1;
          busy      <= 1'b1;
        end
        S_RND: begin
          state  <= S_WAIT;
          tcnt   <= '0;
          run_en <= 1'b1;
          busy   <= 1'b1;
        end
        S_WAIT: begin
          if (Done_rnd) begin
            state <= S_FSTEP;
            en_F  <= 1'b1;
            busy  <= 1'b1;
          end else if (tcnt == T_LAST) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            tcnt   <= tcnt + 1'b1;
            run_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_FSTEP: begin
          state   <= S_UPD;
          en_regs <= 1'b1;
          en_c    <= 1'b1;
          busy    <= 1'b1;
        end
        S_UPD: begin
          if (cout) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_RND;
            start_rnd <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
